// File: rtl/sysarray_feed_ctrl.sv
// ---------------------------------------------------------------------------
// sysarray_feed_ctrl
//
// Operand sequencer for the 4x3 sysarray systolic MAC array.  Holds an A
// matrix (4 x K) and a B matrix (K x 3) written through a simple write port.
// A start request clears the array accumulators for one cycle, then streams
// diagonally skewed operands into a1..a4 / b1..b3, feeds zeros while the
// pipeline drains, and pulses done once the array outputs hold C = A x B.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   wr_en, wr_sel      operand write strobe; 0 = A store, 1 = B store
//   wr_row, wr_col     A: row i / column k   B: row k / column j
//   wr_data            operand value
//   k_len              inner dimension K, sampled with start
//   start              single-cycle run request
//   busy               high while a run is in progress
//   done               one-cycle pulse when the array results are valid
//   err                one-cycle pulse when a start is rejected (bad K)
//   arr_clr            clears the array accumulators
//   a1..a4, b1..b3     row / column operand feeds
// ---------------------------------------------------------------------------
module sysarray_feed_ctrl #(
    parameter int KMAX      = 8,
    parameter int DW        = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [$clog2(KMAX)-1:0] wr_row,
    input  logic [$clog2(KMAX)-1:0] wr_col,
    input  logic [DW-1:0]           wr_data,
    input  logic [$clog2(KMAX):0]   k_len,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    arr_clr,
    output logic [DW-1:0]           a1,
    output logic [DW-1:0]           a2,
    output logic [DW-1:0]           a3,
    output logic [DW-1:0]           a4,
    output logic [DW-1:0]           b1,
    output logic [DW-1:0]           b2,
    output logic [DW-1:0]           b3
);

    localparam int AW  = $clog2(KMAX);
    localparam int KW  = AW + 1;
    localparam int SW  = $clog2(KMAX + 3) + 1;
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [AW:0]   IDX_LIM  = (AW + 1)'(KMAX);
    localparam logic [AW:0]   A_ROWS   = (AW + 1)'(4);
    localparam logic [AW:0]   B_COLS   = (AW + 1)'(3);
    localparam logic [KW-1:0] K_MAX_V  = KW'(KMAX);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [KW-1:0]   k_q, k_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            clr_q, clr_d;
    logic [DW-1:0]   a_feed_q [4];
    logic [DW-1:0]   a_feed_d [4];
    logic [DW-1:0]   b_feed_q [3];
    logic [DW-1:0]   b_feed_d [3];

    logic [DW-1:0]   a_mem_q [4][KMAX];
    logic [DW-1:0]   b_mem_q [KMAX][3];

    logic            a_wr;
    logic            b_wr;
    logic            k_ok;
    logic [SW-1:0]   last_step;
    logic [SW-1:0]   a_diff [4];
    logic [SW-1:0]   b_diff [3];

    // Writes land only while idle so a running sequence always sees a
    // stable operand set; indices outside the physical stores are dropped
    // rather than aliased onto a valid entry.
    always_comb begin
        a_wr = wr_en && (state_q == IDLE) && !wr_sel
               && ({1'b0, wr_row} < A_ROWS) && ({1'b0, wr_row} < IDX_LIM)
               && ({1'b0, wr_col} < IDX_LIM);
        b_wr = wr_en && (state_q == IDLE) && wr_sel
               && ({1'b0, wr_row} < IDX_LIM)
               && ({1'b0, wr_col} < B_COLS) && ({1'b0, wr_col} < IDX_LIM);
    end

    // Operand stores persist across runs and are only cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < KMAX; k++) begin
                    a_mem_q[i][k] <= '0;
                end
            end
            for (int k = 0; k < KMAX; k++) begin
                for (int j = 0; j < 3; j++) begin
                    b_mem_q[k][j] <= '0;
                end
            end
        end else begin
            if (a_wr) begin
                a_mem_q[wr_row[1:0]][wr_col] <= wr_data;
            end
            if (b_wr) begin
                b_mem_q[wr_row][wr_col[1:0]] <= wr_data;
            end
        end
    end

    // Sequencer next-state logic.  step counts the skewed stream from 0 to
    // K+2 so the last row/column operand (index K-1 delayed by 3) gets out.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        drain_d   = drain_q;
        k_d       = k_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        clr_d     = 1'b0;
        k_ok      = (k_len != '0) && (k_len <= K_MAX_V);
        last_step = SW'(k_q) + SW'(2);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_ok) begin
                        state_d = CLEAR;
                        k_d     = k_len;
                        clr_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = STREAM;
                step_d  = '0;
            end
            STREAM: begin
                if (step_q == last_step) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LAST;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Skewed operand selection for the step about to be presented: row i
    // lags by i cycles, column j lags by j cycles, zero outside 0..K-1.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_diff[i]   = step_d - SW'(i);
            a_feed_d[i] = '0;
            if ((state_d == STREAM) && (step_d >= SW'(i)) && (a_diff[i] < SW'(k_q))) begin
                a_feed_d[i] = a_mem_q[i][a_diff[i][AW-1:0]];
            end
        end
        for (int j = 0; j < 3; j++) begin
            b_diff[j]   = step_d - SW'(j);
            b_feed_d[j] = '0;
            if ((state_d == STREAM) && (step_d >= SW'(j)) && (b_diff[j] < SW'(k_q))) begin
                b_feed_d[j] = b_mem_q[b_diff[j][AW-1:0]][j];
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            drain_q <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_feed_q[i] <= '0;
            end
            for (int j = 0; j < 3; j++) begin
                b_feed_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
            for (int i = 0; i < 4; i++) begin
                a_feed_q[i] <= a_feed_d[i];
            end
            for (int j = 0; j < 3; j++) begin
                b_feed_q[j] <= b_feed_d[j];
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign arr_clr = clr_q;
    assign a1      = a_feed_q[0];
    assign a2      = a_feed_q[1];
    assign a3      = a_feed_q[2];
    assign a4      = a_feed_q[3];
    assign b1      = b_feed_q[0];
    assign b2      = b_feed_q[1];
    assign b3      = b_feed_q[2];

endmodule
